// File: rtl/vga_color_display.sv
// 640x480@60 VGA scanner painting the tens colour left and the ones colour right.
// Optional 2-pixel black divider between the halves: define VGA_COLOR_DIVIDER_EN.
module vga_color_display #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] code,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_HALF   = HW'(H_VISIBLE / 2);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);
`ifdef VGA_COLOR_DIVIDER_EN
    localparam logic [HW-1:0] DIV_LO   = HW'(H_VISIBLE / 2 - 1);
`endif

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic [11:0]   rgb_q, rgb_d;
    logic          fs_q, fs_d;
    logic [23:0]   code_q, code_d;

    logic          tick;
    logic          visible;
    logic [11:0]   pix;

    always_comb begin
        div_d   = div_q;
        h_d     = h_q;
        v_d     = v_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        rgb_d   = rgb_q;
        code_d  = code_q;
        fs_d    = 1'b0;
        pix     = 12'h000;

        tick    = (div_q == DIV_LAST);
        visible = (h_q < H_VIS) && (v_q < V_VIS);

        if (visible) begin
            pix = (h_q < H_HALF) ? code_q[23:12] : code_q[11:0];
`ifdef VGA_COLOR_DIVIDER_EN
            if (h_q == DIV_LO || h_q == H_HALF) begin
                pix = 12'h000;
            end
`endif
        end

        div_d = tick ? '0 : div_q + DW'(1);

        // Everything below sees the pre-increment position of this pixel.
        if (tick) begin
            h_d   = (h_q == H_LAST) ? '0 : h_q + HW'(1);
            if (h_q == H_LAST) begin
                v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
            end
            hs_d  = !((h_q >= HS_BEG) && (h_q < HS_END));
            vs_d  = !((v_q >= VS_BEG) && (v_q < VS_END));
            rgb_d = pix;
            if (h_q == H_LAST && v_q == V_LAST) begin
                code_d = code;
                fs_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            h_q    <= '0;
            v_q    <= '0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            rgb_q  <= 12'h000;
            fs_q   <= 1'b0;
            code_q <= 24'hFFFFFF;
        end else begin
            div_q  <= div_d;
            h_q    <= h_d;
            v_q    <= v_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            rgb_q  <= rgb_d;
            fs_q   <= fs_d;
            code_q <= code_d;
        end
    end

    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign red         = rgb_q[11:8];
    assign green       = rgb_q[7:4];
    assign blue        = rgb_q[3:0];
    assign frame_start = fs_q;

endmodule

// File: doc/vga_color_display.md
Name: vga_color_display

Overview:
- Downstream consumer of the 24-bit two-colour code from the BCD colour-code stage.
- Generates 640x480@60 VGA timing from the system clock and paints the visible area in two halves:
  - left half: tens colour, code[23:12]
  - right half: ones colour, code[11:0]
- Samples code once per frame so the picture never tears.
- Drives the board's 12-bit VGA connector directly.

Parameters:
- CLK_DIV, 2, system clocks per pixel (2 for 50 MHz clk, 25 MHz pixel rate); legal 1..8
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- H_SYNC, 96, hsync pulse width in pixels
- H_BACK, 48, horizontal back porch in pixels
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 33, vertical back porch in lines

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  reset; synchronous and active-high; one clock; clears all state
- code  input  24  {tens_rgb[11:0], ones_rgb[11:0]}, each 4:4:4 R,G,B
- hsync  output  1  horizontal sync, active-low
- vsync  output  1  vertical sync, active-low
- red  output  4  red channel
- green  output  4  green channel
- blue  output  4  blue channel
- frame_start  output  1  one-clk pulse when code is sampled

Behaviour:
- Derived totals:
  - H_TOTAL = sum of the four H parameters (800 by default)
  - V_TOTAL = sum of the four V parameters (525 by default)
- Pixel tick:
  - Divider counter runs 0..CLK_DIV-1 and wraps.
  - tick is asserted when the counter equals CLK_DIV-1; with CLK_DIV=1, tick is high every clk.
  - No logic other than the divider advances except on tick.
- Counters:
  - h_cnt 0..H_TOTAL-1, v_cnt 0..V_TOTAL-1.
  - On tick, h_cnt increments. At H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 at V_TOTAL-1 on the same tick that h_cnt wraps.
- Registered outputs update on tick from the pre-increment (h_cnt, v_cnt), i.e. one pixel of latency vs the counters:
  - hsync = 0 iff H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC (656..751 default).
  - vsync = 0 iff V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC (490..491 default).
  - visible = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
  - RGB = code_lat[23:12] if visible && h_cnt < H_VISIBLE/2.
  - RGB = code_lat[11:0] if visible && h_cnt >= H_VISIBLE/2.
  - RGB = 12'h000 when not visible (blanking must be black).
- Frame sampling:
  - code_lat <= code on the tick where h_cnt==H_TOTAL-1 and v_cnt==V_TOTAL-1.
  - frame_start is high for exactly that one clk (tick-qualified) and low otherwise.
  - Changes to code at any other time have no visible effect until the next frame.
- Reset values:
  - Divider, h_cnt, v_cnt = 0.
  - hsync = 1, vsync = 1.
  - red/green/blue = 0, frame_start = 0.
  - code_lat = 24'hFFFFFF (white/white until the first sample).
- Reset mid-frame: on the next clk all state returns to the reset values; scanning restarts at (0,0) with no partial sync pulse retained.
- Pixel boundary inside one tick period: outputs hold stable for all CLK_DIV clks of a pixel.
- No handshake on code; it is treated as quasi-static, and only the per-frame sample matters.

Optional Feature:
- Macro: VGA_COLOR_DIVIDER_EN
- Defined:
  - Visible pixels with h_cnt in {H_VISIBLE/2-1, H_VISIBLE/2} (319 and 320 default) are forced to 12'h000, giving a 2-pixel black divider between the two colours.
  - All other behaviour is unchanged.
- Undefined: no divider; pixel 319 shows the tens colour and pixel 320 the ones colour.

Test Plan:
- Reset:
  - Hold rst 3 clks, release.
  - Before the first tick: hsync=1, vsync=1, rgb=0, frame_start=0.
  - First visible pixel shows 12'hFFF on both halves until the first frame_start.
- Horizontal timing (CLK_DIV=2):
  - Measure over 3 lines: hsync period = 1600 clks.
  - hsync low width = 192 clks.
  - Falling edge 1312 clks after the line's first pixel output.
- Vertical timing:
  - vsync period = 525 lines = 840000 clks.
  - Low width = 2 lines = 3200 clks.
  - frame_start pulses once per 840000 clks.
- Colour split:
  - Drive code=24'hF00_0F0 (num 12) before frame_start.
  - Next frame: pixels 0..319 = R=F,G=0,B=0; pixels 320..639 = R=0,G=F,B=0.
  - Pixels 640..799 and lines 480..524 = 0.
- Tear-free:
  - Change code to 24'h00F_FC0 at line 200 of a frame.
  - Rest of that frame stays red/green.
  - The following frame shows blue/yellow.
- Divider macro and CLK_DIV=1:
  - With VGA_COLOR_DIVIDER_EN, pixels 319 and 320 = 0 while 318 is the tens colour and 321 the ones colour.
  - With CLK_DIV=1, hsync period = 800 clks.
